gpio_scan_sequencer: RTL

- Drives the GPIO serial path of the SRAM test chip. It replaces manual pad toggling with a single start/done transaction.
- Serialises a 112-bit instruction word into the chip's scan register (MSB first), then pulses the SRAM clock.
- After the SRAM clock, it waits for dout to settle, strobes the SRAM-load capture, and deserialises the 112-bit result (LSB first).
- Sits directly upstream of the test-chip core. Its outputs connect to gpio_in_scan, gpio_bit, gpio_sram_clk, gpio_sram_load and gpio_out_scan; it consumes gpio_data0.

---
 rtl/scan_pkg.sv | 41 ++++
 rtl/scan_shifter.sv | 54 +++++
 rtl/gpio_scan_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the GPIO scan sequencer and its bench:
// FSM state encoding, operation modes and the instruction-word field map.
package scan_pkg;

  localparam int REG_WIDTH_DEFAULT = 112;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_SRAM_CLK,
    ST_WAIT,
    ST_LOAD,
    ST_SHIFT_OUT,
    ST_DONE
  } scan_state_t;

  localparam logic [1:0] OP_FULL = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_OUT  = 2'b10;

  // Field positions inside the 112-bit instruction word (bit 111 is scanned first)
  localparam int CS_MSB     = 111;
  localparam int CS_LSB     = 108;
  localparam int ADDR0_MSB  = 107;
  localparam int ADDR0_LSB  = 92;
  localparam int DIN0_MSB   = 91;
  localparam int DIN0_LSB   = 60;
  localparam int CSB0_BIT   = 59;
  localparam int WEB0_BIT   = 58;
  localparam int WMASK0_MSB = 57;
  localparam int WMASK0_LSB = 54;
  localparam int ADDR1_MSB  = 53;
  localparam int ADDR1_LSB  = 38;
  localparam int DIN1_MSB   = 37;
  localparam int DIN1_LSB   = 6;
  localparam int CSB1_BIT   = 5;
  localparam int WEB1_BIT   = 4;
  localparam int WMASK1_MSB = 3;
  localparam int WMASK1_LSB = 0;

endpackage

// File: rtl/scan_shifter.sv
// Datapath for the scan sequencer: parallel-load PISO for the instruction,
// SIPO for the returned word, and a shared saturating bit counter.
module scan_shifter #(
  parameter int W     = 112,
  parameter int CNT_W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_tx_word,
  input  logic         i_clr_cnt,
  input  logic         i_shift_in,
  input  logic         i_shift_out,
  input  logic         i_din,
  output logic         o_msb,
  output logic [W-1:0] o_rx_word,
  output logic         o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  logic [W-1:0]     r_tx_shift;
  logic [W-1:0]     r_rx_word;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_last;

  assign w_last    = (r_bit_cnt == LAST_CNT);
  assign o_last    = w_last;
  assign o_msb     = r_tx_shift[W-1];
  assign o_rx_word = r_rx_word;

  // Counter holds at the terminal value; the FSM clears it before each reuse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_shift <= '0;
      r_rx_word  <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (i_load)
        r_tx_shift <= i_tx_word;
      else if (i_shift_in)
        r_tx_shift <= {r_tx_shift[W-2:0], 1'b0};

      if (i_shift_out)
        r_rx_word <= {i_din, r_rx_word[W-1:1]};

      if (i_load || i_clr_cnt)
        r_bit_cnt <= '0;
      else if ((i_shift_in || i_shift_out) && !w_last)
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_scan_sequencer.sv
// Sequences one SRAM test-chip transaction over the GPIO scan path:
// scan in an instruction, clock the SRAM, capture dout and scan the result out.
module gpio_scan_sequencer
  import scan_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEFAULT,
  parameter int CNT_W     = 7,
  parameter int SRAM_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           op_mode,
  input  logic [REG_WIDTH-1:0] tx_word,
  input  logic                 scan_data_in,
  output logic                 scan_bit,
  output logic                 in_scan,
  output logic                 sram_strobe,
  output logic                 sram_load,
  output logic                 out_scan,
  output logic [REG_WIDTH-1:0] rx_word,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] WAIT_LAST = (SRAM_WAIT == 0) ? 4'd0 : 4'(SRAM_WAIT - 1);

  scan_state_t r_state;
  scan_state_t w_next;
  logic [1:0]  r_mode;
  logic [3:0]  r_wait_cnt;

  logic r_in_scan, r_sram_strobe, r_sram_load, r_out_scan;
  logic r_busy, r_done, r_rx_valid;

  logic w_accept, w_last, w_msb;

  assign w_accept = (r_state == ST_IDLE) && start && !abort;

  scan_shifter #(
    .W     (REG_WIDTH),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_load      (w_accept),
    .i_tx_word   (tx_word),
    .i_clr_cnt   (r_state == ST_LOAD),
    .i_shift_in  (r_state == ST_SHIFT_IN),
    .i_shift_out (r_state == ST_SHIFT_OUT),
    .i_din       (scan_data_in),
    .o_msb       (w_msb),
    .o_rx_word   (rx_word),
    .o_last      (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= OP_FULL;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_mode <= op_mode;
      if (r_state == ST_WAIT)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
    end
  end

  // Abort overrides every transition, including an accept in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = (op_mode == OP_OUT) ? ST_SHIFT_OUT : ST_SHIFT_IN;
      ST_SHIFT_IN:  if (w_last) w_next = (r_mode == OP_IN) ? ST_DONE : ST_SRAM_CLK;
      ST_SRAM_CLK:  w_next = (SRAM_WAIT == 0) ? ST_LOAD : ST_WAIT;
      ST_WAIT:      if (r_wait_cnt == WAIT_LAST) w_next = ST_LOAD;
      ST_LOAD:      w_next = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (w_last) w_next = ST_DONE;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (abort)
      w_next = ST_IDLE;
  end

  // Strobes are flopped from the next state so pads see glitch-free levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_scan     <= 1'b0;
      r_sram_strobe <= 1'b0;
      r_sram_load   <= 1'b0;
      r_out_scan    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rx_valid    <= 1'b0;
    end else begin
      r_in_scan     <= (w_next == ST_SHIFT_IN);
      r_sram_strobe <= (w_next == ST_SRAM_CLK);
      r_sram_load   <= (w_next == ST_LOAD);
      r_out_scan    <= (w_next == ST_SHIFT_OUT);
      r_busy        <= (w_next != ST_IDLE);
      r_done        <= (w_next == ST_DONE);
      r_rx_valid    <= (w_next == ST_DONE) && (r_state == ST_SHIFT_OUT);
    end
  end

  assign scan_bit    = r_in_scan & w_msb;
  assign in_scan     = r_in_scan;
  assign sram_strobe = r_sram_strobe;
  assign sram_load   = r_sram_load;
  assign out_scan    = r_out_scan;
  assign busy        = r_busy;
  assign done        = r_done;
  assign rx_valid    = r_rx_valid;

endmodule
